runway_scheduler: RTL and testbench

//  Arbitrates landing/takeoff requests from N_REQ aircraft slots onto two runways (A, B).

---
 rtl/rwy_pkg.sv | 20 ++
 rtl/runway_timer.sv | 82 ++++++++
 rtl/runway_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_runway_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rwy_pkg.sv
// Shared runway types, runway identifiers and the tower lamp encoding.
package rwy_pkg;

  typedef enum logic [1:0] {
    RWY_FREE     = 2'b00,
    RWY_OCCUPIED = 2'b01,
    RWY_CLEAR    = 2'b10
  } rwy_state_t;

  localparam logic RWY_A = 1'b0;
  localparam logic RWY_B = 1'b1;

  localparam logic [3:0] SIGNAL_IDLE = 4'b1011;

  // Lamp word: {always-on, both busy, not both busy, A free}
  function automatic logic [3:0] lamp_word(input logic busy_a_v, input logic busy_b_v);
    return {1'b1, busy_a_v & busy_b_v, ~(busy_a_v & busy_b_v), ~busy_a_v};
  endfunction

endpackage

// File: rtl/runway_timer.sv
// One runway: FREE -> OCCUPIED -> CLEAR -> FREE, with a shared down-counting timer.
module runway_timer
  import rwy_pkg::*;
#(
  parameter int OCC_CYCLES = 15,
  parameter int GAP_CYCLES = 2,
  parameter int TMR_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output rwy_state_t state
);

  localparam logic [TMR_W-1:0] OCC_LOAD = TMR_W'(OCC_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1'b1);

  rwy_state_t       state_r;
  rwy_state_t       state_nxt_s;
  logic [TMR_W-1:0] tmr_r;
  logic [TMR_W-1:0] tmr_nxt_s;
  logic             busy_r;

  // Next-state and timer reload/decrement
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r;
    case (state_r)
      RWY_FREE: begin
        if (start) begin
          state_nxt_s = RWY_OCCUPIED;
          tmr_nxt_s   = OCC_LOAD;
        end else begin
          state_nxt_s = RWY_FREE;
          tmr_nxt_s   = TMR_ZERO;
        end
      end
      RWY_OCCUPIED: begin
        if (tmr_r == TMR_ZERO) begin
          state_nxt_s = RWY_CLEAR;
          tmr_nxt_s   = GAP_LOAD;
        end else begin
          state_nxt_s = RWY_OCCUPIED;
          tmr_nxt_s   = tmr_r - TMR_ONE;
        end
      end
      RWY_CLEAR: begin
        if (tmr_r == TMR_ZERO) begin
          state_nxt_s = RWY_FREE;
          tmr_nxt_s   = TMR_ZERO;
        end else begin
          state_nxt_s = RWY_CLEAR;
          tmr_nxt_s   = tmr_r - TMR_ONE;
        end
      end
      default: begin
        state_nxt_s = RWY_FREE;
        tmr_nxt_s   = TMR_ZERO;
      end
    endcase
  end

  // State, timer and busy flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RWY_FREE;
      tmr_r   <= TMR_ZERO;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
      busy_r  <= (state_nxt_s != RWY_FREE);
    end
  end

  assign busy  = busy_r;
  assign state = state_r;

endmodule

// File: rtl/runway_scheduler.sv
// Two-runway grant arbiter: emergency-first, then round-robin; drives the tower lamp word.
// Optional request aging is enabled by defining RWY_AGING_EN.
module runway_scheduler
  import rwy_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int OCC_CYCLES = 15,
  parameter int GAP_CYCLES = 2,
`ifdef RWY_AGING_EN
  parameter int AGE_LIMIT  = 31,
`endif
  parameter int TMR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_land,
  input  logic [N_REQ-1:0] emerg,
  output logic [N_REQ-1:0] grant,
  output logic             grant_rwy,
  output logic             busy_a,
  output logic             busy_b,
  output logic [3:0]       signal
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] grant_nxt_s;
  logic [N_REQ-1:0] eligible_s;
  logic [N_REQ-1:0] prio_s;
  logic [N_REQ-1:0] aged_s;
  logic             grant_rwy_r;
  logic             grant_valid_s;
  logic             rwy_sel_s;
  logic             rwy_ok_s;
  logic             land_s;
  logic             prio_hit_s;
  logic             rr_hit_s;
  logic             sel_hit_s;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic [IDX_W-1:0] prio_idx_s;
  logic [IDX_W-1:0] rr_idx_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [IDX_W:0]   rot_sum_s [N_REQ];
  logic [IDX_W-1:0] rot_idx_s [N_REQ];
  logic             start_a_s;
  logic             start_b_s;
  logic             busy_a_s;
  logic             busy_b_s;
  logic             free_a_s;
  logic             free_b_s;
  rwy_state_t       state_a_s;
  rwy_state_t       state_b_s;

`ifdef RWY_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_ZERO = {AGE_W{1'b0}};
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1'b1);

  logic [AGE_W-1:0] wait_r [N_REQ];

  // Saturating wait counters; any grant or dropped request restarts the wait
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst || !req[i] || grant_nxt_s[i]) begin
        wait_r[i] <= AGE_ZERO;
      end else if (wait_r[i] != AGE_MAX) begin
        wait_r[i] <= wait_r[i] + AGE_ONE;
      end else begin
        wait_r[i] <= wait_r[i];
      end
    end
  end

  // Long-waiting slots are promoted into the emergency class
  always_comb begin
    aged_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      aged_s[i] = (wait_r[i] >= AGE_MAX);
    end
  end
`else
  assign aged_s = {N_REQ{1'b0}};
`endif

  // Round-robin visiting order starting at the pointer
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      rot_sum_s[k] = {1'b0, ptr_r} + (IDX_W + 1)'(k);
      rot_idx_s[k] = (rot_sum_s[k] >= N_REQ_W) ? IDX_W'(rot_sum_s[k] - N_REQ_W)
                                               : rot_sum_s[k][IDX_W-1:0];
    end
  end

  assign free_a_s = (state_a_s == RWY_FREE);
  assign free_b_s = (state_b_s == RWY_FREE);

  // Slot selection, runway choice and next grant / pointer
  always_comb begin
    // A slot granted this cycle is masked so a late req drop cannot double-grant it
    eligible_s = req & ~grant_r;
    prio_s     = eligible_s & (emerg | aged_s);

    prio_hit_s = 1'b0;
    prio_idx_s = IDX_ZERO;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      prio_hit_s = prio_s[i] ? 1'b1 : prio_hit_s;
      prio_idx_s = prio_s[i] ? IDX_W'(i) : prio_idx_s;
    end

    rr_hit_s = 1'b0;
    rr_idx_s = IDX_ZERO;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_hit_s = eligible_s[rot_idx_s[k]] ? 1'b1 : rr_hit_s;
      rr_idx_s = eligible_s[rot_idx_s[k]] ? rot_idx_s[k] : rr_idx_s;
    end

    sel_hit_s = prio_hit_s | rr_hit_s;
    sel_idx_s = prio_hit_s ? prio_idx_s : rr_idx_s;
    land_s    = req_land[sel_idx_s];

    if (land_s) begin
      if (free_a_s) begin
        rwy_ok_s  = 1'b1;
        rwy_sel_s = RWY_A;
      end else if (free_b_s) begin
        rwy_ok_s  = 1'b1;
        rwy_sel_s = RWY_B;
      end else begin
        rwy_ok_s  = 1'b0;
        rwy_sel_s = RWY_A;
      end
    end else begin
      if (free_b_s) begin
        rwy_ok_s  = 1'b1;
        rwy_sel_s = RWY_B;
      end else if (free_a_s) begin
        rwy_ok_s  = 1'b1;
        rwy_sel_s = RWY_A;
      end else begin
        rwy_ok_s  = 1'b0;
        rwy_sel_s = RWY_B;
      end
    end

    grant_valid_s = sel_hit_s & rwy_ok_s;

    if (grant_valid_s) begin
      grant_nxt_s = N_REQ'(1'b1) << sel_idx_s;
    end else begin
      grant_nxt_s = {N_REQ{1'b0}};
    end

    // Emergency (and promoted) grants leave the rotation untouched
    if (grant_valid_s && !prio_hit_s) begin
      ptr_nxt_s = (sel_idx_s == IDX_LAST) ? IDX_ZERO : (sel_idx_s + IDX_ONE);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  assign start_a_s = grant_valid_s & (rwy_sel_s == RWY_A);
  assign start_b_s = grant_valid_s & (rwy_sel_s == RWY_B);

  // Grant, runway and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r     <= {N_REQ{1'b0}};
      grant_rwy_r <= RWY_A;
      ptr_r       <= IDX_ZERO;
    end else begin
      grant_r     <= grant_nxt_s;
      grant_rwy_r <= grant_valid_s ? rwy_sel_s : RWY_A;
      ptr_r       <= ptr_nxt_s;
    end
  end

  runway_timer #(
    .OCC_CYCLES (OCC_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .TMR_W      (TMR_W)
  ) u_rwy_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_a_s),
    .busy  (busy_a_s),
    .state (state_a_s)
  );

  runway_timer #(
    .OCC_CYCLES (OCC_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .TMR_W      (TMR_W)
  ) u_rwy_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_b_s),
    .busy  (busy_b_s),
    .state (state_b_s)
  );

  assign grant     = grant_r;
  assign grant_rwy = grant_rwy_r;
  assign busy_a    = busy_a_s;
  assign busy_b    = busy_b_s;
  // Decoded straight from the busy flops, so it changes on the same edge as busy_a/busy_b
  assign signal    = lamp_word(busy_a_s, busy_b_s);

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed, table-driven bench for runway_scheduler (default parameters).
module tb_runway_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_land;
  logic [3:0] emerg;
  logic [3:0] grant;
  logic       grant_rwy;
  logic       busy_a;
  logic       busy_b;
  logic [3:0] signal;

  always #5 clk = ~clk;

  runway_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_land  (req_land),
    .emerg     (emerg),
    .grant     (grant),
    .grant_rwy (grant_rwy),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .signal    (signal)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] land;
    logic [3:0] emerg;
    logic [3:0] grant;
    logic       rwy;
    logic       ba;
    logic       bb;
    logic [3:0] sig;
  } vec_t;

  vec_t vt[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ld,
                     input logic [3:0] em, input logic [3:0] gr, input logic rw,
                     input logic ba, input logic bb, input logic [3:0] sg);
    vt.push_back('{r, rq, ld, em, gr, rw, ba, bb, sg});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst      = vt[i].rst;
      req      = vt[i].req;
      req_land = vt[i].land;
      emerg    = vt[i].emerg;
      tick();
      check($sformatf("row%0d grant", i), 32'(grant), 32'(vt[i].grant));
      if (vt[i].grant != 4'b0000)
        check($sformatf("row%0d grant_rwy", i), 32'(grant_rwy), 32'(vt[i].rwy));
      check($sformatf("row%0d busy_a", i), 32'(busy_a), 32'(vt[i].ba));
      check($sformatf("row%0d busy_b", i), 32'(busy_b), 32'(vt[i].bb));
      check($sformatf("row%0d signal", i), 32'(signal), 32'(vt[i].sig));
    end
  endtask

  task automatic wait_grant(input int bound, output int steps, output logic [3:0] g);
    steps = 0;
    g     = 4'b0000;
    while (steps < bound) begin
      tick();
      steps++;
      if (grant != 4'b0000) begin
        g = grant;
        break;
      end
    end
  endtask

  initial begin
    int         g1_lo, g1_hi, g2_lo, g2_hi, g3_lo, g3_hi, g5_lo, g5_hi;
    int         n;
    int         nb;
    int         bad;
    logic [3:0] g;
    logic [3:0] exp_seq [5];

    rst = 1'b1; req = 4'b0000; req_land = 4'b0000; emerg = 4'b0000;

    // rst, req, land, emerg | grant, rwy, busy_a, busy_b, signal
    g1_lo = vt.size();
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1011);
    add(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1010);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1010);
    g1_hi = vt.size();
    g2_lo = vt.size();
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1011);
    add(1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b1011);
    add(1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b1, 4'b1100);
    add(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1100);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1100);
    g2_hi = vt.size();
    g3_lo = vt.size();
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1011);
    add(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b1011);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1011);
    add(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b1100);
    add(1'b0, 4'b0110, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1100);
    g3_hi = vt.size();
    g5_lo = vt.size();
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1011);
    add(1'b0, 4'b0011, 4'b0011, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1010);
    add(1'b0, 4'b0011, 4'b0011, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b1100);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1100);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1100);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1100);
    add(1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1011);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b1011);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1011);
    g5_hi = vt.size();

    // Single landing: runway A busy for exactly OCC+GAP cycles
    run_rows(g1_lo, g1_hi);
    nb = 2;
    n  = 0;
    while (busy_a === 1'b1 && n < 30) begin
      tick();
      n++;
      if (busy_a === 1'b1) nb++;
    end
    check("t1 busy_a cycles", 32'(nb), 32'd17);
    check("t1 signal after free", 32'(signal), 32'hB);

    // Two takeoffs in one cycle, grant mask, withdrawn request
    run_rows(g2_lo, g2_hi);

    // Emergency slot beats the round-robin favourite once a runway frees
    run_rows(g3_lo, g3_hi);
    wait_grant(40, n, g);
    check("t3 emerg grant", 32'(g), 32'b0100);
    check("t3 emerg wait", 32'(n), 32'd15);
    check("t3 emerg rwy", 32'(grant_rwy), 32'd1);
    req = 4'b0010; emerg = 4'b0000;
    wait_grant(40, n, g);
    check("t3 normal grant", 32'(g), 32'b0010);
    check("t3 normal wait", 32'(n), 32'd2);
    check("t3 normal rwy", 32'(grant_rwy), 32'd0);
    req = 4'b0000;

    // Continuous requests rotate 0,1,2,3,0
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; req_land = 4'b0000; emerg = 4'b0000;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      wait_grant(40, n, g);
      check($sformatf("t4 rotation %0d", k), 32'(g), 32'(exp_seq[k]));
    end
    req = 4'b0000;

    // Reset in the middle of occupancy, pending request granted right after
    run_rows(g5_lo, g5_hi);

`ifdef RWY_AGING_EN
    // An aged takeoff request overtakes a fresh normal request
    rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
    req = 4'b0001; emerg = 4'b0001; req_land = 4'b0001;
    wait_grant(5, n, g);
    check("t6 hog A", 32'(g), 32'b0001);
    wait_grant(5, n, g);
    check("t6 hog B", 32'(g), 32'b0001);
    req = 4'b1001;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (grant[3] === 1'b1) bad++;
    end
    check("t6 slot3 held off", 32'(bad), 32'd0);
    req = 4'b1010; emerg = 4'b0000; req_land = 4'b0000;
    wait_grant(60, n, g);
    check("t6 aged grant", 32'(g), 32'b1000);
    req = 4'b0000;
`else
    bad = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
